// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types, funct3 encodings and helper functions for the
//            byte-serial load/store unit.
// Contents : F3_* funct3 constants, lsu_state_t FSM state enum,
//            bytes_for() byte-count lookup, is_legal() request legality.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    // RISC-V load/store funct3 encodings (size in [1:0], unsigned in [2])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    // Number of bytes moved for a given funct3. Only the size field matters;
    // illegal encodings never reach ACCESS, so their value is irrelevant.
    function automatic logic [2:0] bytes_for(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   bytes_for = 3'd1;
            2'b01:   bytes_for = 3'd2;
            default: bytes_for = 3'd4;
        endcase
    endfunction

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic is_legal(input logic store, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : lsu_pkg

`default_nettype wire

// File: rtl/load_store_unit_load_ext.sv
// ============================================================================
// Module   : lsu_load_ext
// Purpose  : Combinational sign/zero extension of assembled load data.
// Ports    : funct3 [2:0]   - load type selecting the extension
//            data   [XLEN]  - little-endian assembled load bytes
//            rdata  [XLEN]  - extended result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] rdata
);

    always_comb begin
        rdata = data;
        case (funct3)
            F3_B:    rdata = {{(XLEN-8){data[7]}},   data[7:0]};
            F3_H:    rdata = {{(XLEN-16){data[15]}}, data[15:0]};
            F3_BU:   rdata = {{(XLEN-8){1'b0}},      data[7:0]};
            F3_HU:   rdata = {{(XLEN-16){1'b0}},     data[15:0]};
            default: rdata = data;
        endcase
    end

endmodule : lsu_load_ext

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Converts one RISC-V load/store request into a byte-serial
//            sequence of accesses to a byte-wide data memory, assembles load
//            bytes little-endian, extends them and returns one response.
// Ports    : clk, reset                       - clock, sync active-high reset
//            req_valid/req_ready              - request handshake
//            req_store, req_funct3, req_addr,
//            req_wdata                        - request payload
//            resp_valid/resp_ready            - response handshake
//            resp_rdata, resp_err             - response payload
//            mem_addr, mem_re, mem_we,
//            mem_wdata, mem_rdata             - byte memory interface
// Config   : LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//            accesses are rejected with resp_err instead of being performed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int IDX_W = $clog2(XLEN / 8);

    lsu_state_t        r_state;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_data;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_last;
    logic              r_err;

    logic              w_misalign;
    logic              w_access;
    logic [XLEN-1:0]   w_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_data   <= '0;
            r_idx    <= '0;
            r_last   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // req_ready is high exactly in IDLE, so req_valid alone
                    // completes the handshake here.
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_data   <= '0;
                        r_idx    <= '0;
                        r_last   <= IDX_W'(bytes_for(req_funct3) - 3'd1);
                        if (!is_legal(req_store, req_funct3) || w_misalign) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!r_store) begin
                        r_data[{r_idx, 3'b000} +: 8] <= mem_rdata;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == r_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    lsu_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .funct3 (r_funct3),
        .data   (r_data),
        .rdata  (w_ext)
    );

    // Gating with !reset guarantees no memory strobe in a reset cycle, which
    // is what stops a store that is interrupted mid-word.
    assign w_access   = (r_state == ACCESS) && !reset;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_err && !r_store) ? w_ext : '0;

    assign mem_re     = w_access && !r_store;
    assign mem_we     = w_access && r_store;
    assign mem_addr   = w_access ? (r_addr + ADDR_W'(r_idx)) : '0;
    assign mem_wdata  = mem_we ? r_wdata[{r_idx, 3'b000} +: 8] : 8'h00;

endmodule : load_store_unit

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a
//            byte-wide memory model. Honours LSU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_store  = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr   = 32'h0;
    logic [31:0] req_wdata  = 32'h0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        mem_init = 1'b1;
    logic [7:0]  mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .XLEN   (32),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Byte memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h201] <= 8'h5A;
        end else if (mem_we) begin
            mem[mem_addr[11:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[11:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction. Latency k counts cycles after the accepting edge
    // (k=1 is cycle T+1). With hold>0 resp_ready is held low for hold extra
    // cycles once the response appears.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_we, input int exp_re);
        bit seen;
        int lat, we_cnt, re_cnt;
        seen = 0; lat = 0; we_cnt = 0; re_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; resp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            if (resp_valid) begin
                seen = 1;
                lat  = k;
                chk({tag, "_rdata"}, resp_rdata, exp_rdata);
                chk({tag, "_err"}, resp_err, exp_err);
            end
        end
        if (!seen) begin
            chk({tag, "_resp_timeout"}, 0, 1);
        end else begin
            chk({tag, "_lat"}, lat, exp_lat);
            chk({tag, "_we_cycles"}, we_cnt, exp_we);
            chk({tag, "_re_cycles"}, re_cnt, exp_re);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, resp_valid, 1);
                chk({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
                chk({tag, "_hold_err"}, resp_err, exp_err);
                chk({tag, "_hold_req_ready"}, req_ready, 0);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            chk({tag, "_idle_ready"}, req_ready, 1);
            chk({tag, "_idle_valid"}, resp_valid, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        mem_init = 1'b0;

        // 1: SW 0xDEADBEEF @0x100
        do_req("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 5, 4, 0);
        chk("sw100_m0", mem[12'h100], 8'hEF);
        chk("sw100_m1", mem[12'h101], 8'hBE);
        chk("sw100_m2", mem[12'h102], 8'hAD);
        chk("sw100_m3", mem[12'h103], 8'hDE);

        // 2: word and byte loads
        do_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 5, 0, 4);
        do_req("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'hFFFFFFDE, 1'b0, 2, 0, 1);
        do_req("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h000000DE, 1'b0, 2, 0, 1);

        // 3: halfword loads
        do_req("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'hFFFFDEAD, 1'b0, 3, 0, 2);
        do_req("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h0000DEAD, 1'b0, 3, 0, 2);

        // 4: misaligned halfword
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lh101", 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 1'b1, 1, 0, 0);
`else
        do_req("lh101", 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'hFFFFADBE, 1'b0, 3, 0, 2);
`endif

        // 5: back-pressured response, then illegal funct3
        do_req("lw_hold", 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, 5, 0, 4);
        do_req("ill011", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1, 1, 0, 0);
        do_req("ill_sbu", 1'b1, 3'b100, 32'h300, 32'h12345678, 0, 32'h0, 1'b1, 1, 0, 0);
        chk("ill_sbu_mem", mem[12'h300], 8'h00);

        // 6: reset in the 2nd ACCESS cycle of SW 0x11223344 @0x200
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h200; req_wdata = 32'h11223344; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst6_we_first", mem_we, 1);
        chk("rst6_wdata_first", mem_wdata, 8'h44);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst6_we_gated", mem_we, 0);
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 1'b0;
        chk("rst6_req_ready", req_ready, 1);
        chk("rst6_resp_valid", resp_valid, 0);
        chk("rst6_m200", mem[12'h200], 8'h44);
        chk("rst6_m201", mem[12'h201], 8'h5A);

        // Recovery after reset
        do_req("lbu200", 1'b0, 3'b100, 32'h200, 32'h0, 0, 32'h00000044, 1'b0, 2, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_load_store_unit

`default_nettype wire
